// File: rtl/xnor_match_pkg.sv
// Shared types, mode encodings and sizing helper for the XNOR frame matcher.
package xnor_match_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} fsmState;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_THRESH = 1'b1;

    // Like $clog2 but never returns 0, so it is always usable as a vector width.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/_and.sv
// N-input AND gate primitive; the supply pair is carried for netlist parity only.
module _and #(
    parameter int INPUT_WIDTH = 2
) (
    input  logic [1:0]             DigitSupply,
    input  logic [INPUT_WIDTH-1:0] inputs,
    output logic                   out
);

    logic unusedSupply;
    assign unusedSupply = ^DigitSupply;

    assign out = &inputs;

endmodule

// File: rtl/_nor.sv
// N-input NOR gate primitive; the supply pair is carried for netlist parity only.
module _nor #(
    parameter int INPUT_WIDTH = 2
) (
    input  logic [1:0]             DigitSupply,
    input  logic [INPUT_WIDTH-1:0] inputs,
    output logic                   out
);

    logic unusedSupply;
    assign unusedSupply = ^DigitSupply;

    assign out = ~(|inputs);

endmodule

// File: rtl/_or.sv
// N-input OR gate primitive; the supply pair is carried for netlist parity only.
module _or #(
    parameter int INPUT_WIDTH = 2
) (
    input  logic [1:0]             DigitSupply,
    input  logic [INPUT_WIDTH-1:0] inputs,
    output logic                   out
);

    logic unusedSupply;
    assign unusedSupply = ^DigitSupply;

    assign out = |inputs;

endmodule

// File: rtl/xnor_lane.sv
// Combinational compare lane: per-bit XNOR from gate primitives and a masked
// mismatch popcount built as a binary adder tree.
module xnor_lane
    import xnor_match_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MISS_W = clog2_safe(WIDTH + 1)
) (
    input  logic [1:0]        DigitSupply,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [WIDTH-1:0]  mask,
    output logic [WIDTH-1:0]  eq,
    output logic [MISS_W-1:0] miss
);

    localparam int LEAVES = 1 << clog2_safe(WIDTH);

    logic [WIDTH-1:0] andAB;
    logic [WIDTH-1:0] norAB;

    // xnor(a, b) = (a & b) | ~(a | b)
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        _and #(.INPUT_WIDTH(2)) uAnd (
            .DigitSupply(DigitSupply),
            .inputs     ({A[i], B[i]}),
            .out        (andAB[i])
        );
        _nor #(.INPUT_WIDTH(2)) uNor (
            .DigitSupply(DigitSupply),
            .inputs     ({A[i], B[i]}),
            .out        (norAB[i])
        );
        _or #(.INPUT_WIDTH(2)) uOr (
            .DigitSupply(DigitSupply),
            .inputs     ({andAB[i], norAB[i]}),
            .out        (eq[i])
        );
    end

    logic [LEAVES-1:0] missBits;
    logic [MISS_W-1:0] level [LEAVES];

    assign missBits = LEAVES'(~eq & mask);

    // In-place pairwise reduction: each pass halves the number of live partial sums.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            level[i] = MISS_W'(missBits[i]);
        end
        for (int span = LEAVES / 2; span >= 1; span = span / 2) begin
            for (int i = 0; i < span; i++) begin
                level[i] = level[2 * i] + level[2 * i + 1];
            end
        end
        miss = level[0];
    end

endmodule

// File: rtl/xnor_frame_matcher.sv
// Multi-beat frame comparator: accumulates masked mismatches from the lane and
// emits one exact/threshold match verdict per frame with a valid/ready handshake.
module xnor_frame_matcher
    import xnor_match_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(WIDTH * MAX_BEATS + 1),
    localparam int BEAT_W   = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        DigitSupply,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [WIDTH-1:0]  mask,
    input  logic              mode,
    input  logic [CNT_W-1:0]  threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              match,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [BEAT_W-1:0] beat_count,
    output logic              frame_err
);

    localparam int MISS_W = clog2_safe(WIDTH + 1);

    fsmState          state;
    logic             modeQ;
    logic [CNT_W-1:0] thrQ;

    logic [WIDTH-1:0]  unusedEq;
    logic [MISS_W-1:0] miss;

    xnor_lane #(
        .WIDTH (WIDTH),
        .MISS_W(MISS_W)
    ) uLane (
        .DigitSupply(DigitSupply),
        .A          (A),
        .B          (B),
        .mask       (mask),
        .eq         (unusedEq),
        .miss       (miss)
    );

    logic              accept;
    logic              firstBeat;
    logic [CNT_W:0]    accBase;
    logic [CNT_W:0]    accWide;
    logic [CNT_W-1:0]  accNext;
    logic [BEAT_W-1:0] beatsNext;
    logic              forcedEnd;
    logic              modeEff;
    logic [CNT_W-1:0]  thrEff;
    logic              verdict;

    assign accept    = in_valid & in_ready;
    assign firstBeat = (state == IDLE);

    // One extra bit catches the carry so the running total saturates instead of wrapping.
    assign accBase   = firstBeat ? '0 : {1'b0, mismatch_count};
    assign accWide   = accBase + (CNT_W + 1)'(miss);
    assign accNext   = accWide[CNT_W] ? '1 : accWide[CNT_W-1:0];
    assign beatsNext = firstBeat ? BEAT_W'(1) : beat_count + BEAT_W'(1);
    assign forcedEnd = !in_last && (beatsNext == BEAT_W'(MAX_BEATS));

    // Mode and threshold come from the first beat; later beats cannot change them.
    assign modeEff = firstBeat ? mode : modeQ;
    assign thrEff  = firstBeat ? threshold : thrQ;
    assign verdict = !forcedEnd &&
                     ((modeEff == MODE_THRESH) ? (accNext <= thrEff) : (accNext == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            match          <= 1'b0;
            frame_err      <= 1'b0;
            mismatch_count <= '0;
            beat_count     <= '0;
            modeQ          <= MODE_EXACT;
            thrQ           <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        mismatch_count <= accNext;
                        beat_count     <= beatsNext;
                        if (firstBeat) begin
                            modeQ <= mode;
                            thrQ  <= threshold;
                        end
                        if (in_last || forcedEnd) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            match     <= verdict;
                            frame_err <= forcedEnd;
                        end else begin
                            state     <= ACCUM;
                            match     <= 1'b0;
                            frame_err <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_frame_matcher.sv
// Self-checking bench for xnor_frame_matcher: vector table, corner-case sequences
// and randomized frames scored against a frame-level popcount model.
module tb_xnor_frame_matcher;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = $clog2(WIDTH * MAX_BEATS + 1);
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        DigitSupply;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [WIDTH-1:0]  mask;
    logic              mode;
    logic [CNT_W-1:0]  threshold;
    logic              out_valid;
    logic              out_ready;
    logic              match;
    logic [CNT_W-1:0]  mismatch_count;
    logic [BEAT_W-1:0] beat_count;
    logic              frame_err;

    xnor_frame_matcher #(
        .WIDTH    (WIDTH),
        .MAX_BEATS(MAX_BEATS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .DigitSupply   (DigitSupply),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .A             (A),
        .B             (B),
        .mask          (mask),
        .mode          (mode),
        .threshold     (threshold),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .match         (match),
        .mismatch_count(mismatch_count),
        .beat_count    (beat_count),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [7:0]       m;
        logic             md;
        logic [CNT_W-1:0] thr;
        int               expMatch;
        int               expCnt;
    } vecT;

    vecT vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBeat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                           input logic md, input logic [CNT_W-1:0] thr, input logic last);
        A         = a;
        B         = b;
        mask      = m;
        mode      = md;
        threshold = thr;
        in_last   = last;
        in_valid  = 1'b1;
    endtask

    task automatic driveBeat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                             input logic md, input logic [CNT_W-1:0] thr, input logic last);
        int waitCycles = 0;
        setBeat(a, b, m, md, thr, last);
        while (!in_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!in_ready) check("in_ready timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expectVerdict(input string tag, input int m, input int cnt, input int bts,
                                 input int err);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " match"}, match, m);
        check({tag, " mismatch_count"}, mismatch_count, cnt);
        check({tag, " beat_count"}, beat_count, bts);
        check({tag, " frame_err"}, frame_err, err);
    endtask

    task automatic consume(input int stall);
        out_ready = 1'b0;
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8'hFF, 1'b0, 6'd0, 1, 0};
        vecs[1] = '{8'hF0, 8'h00, 8'h0F, 1'b0, 6'd0, 1, 0};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 1'b1, 6'd8, 1, 8};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b1, 6'd7, 0, 8};
        vecs[4] = '{8'h12, 8'h34, 8'h00, 1'b0, 6'd0, 1, 0};
        vecs[5] = '{8'h81, 8'h80, 8'hFF, 1'b0, 6'd0, 0, 1};
        vecs[6] = '{8'h0F, 8'h3C, 8'hF0, 1'b1, 6'd1, 0, 2};
        vecs[7] = '{8'h55, 8'hAA, 8'h3C, 1'b1, 6'd4, 1, 4};

        DigitSupply = 2'b10;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        A           = '0;
        B           = '0;
        mask        = '0;
        mode        = 1'b0;
        threshold   = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset match", match, 0);
        check("reset mismatch_count", mismatch_count, 0);
        check("reset beat_count", beat_count, 0);
        check("reset frame_err", frame_err, 0);
        rst = 1'b0;
        tick();

        // Single-beat vector table; verdict must be visible one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            driveBeat(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].md, vecs[i].thr, 1'b1);
            expectVerdict($sformatf("vec%0d", i), vecs[i].expMatch, vecs[i].expCnt, 1, 0);
            consume(0);
        end

        // Three-beat threshold frame, mismatches 1,0,1.
        driveBeat(8'h5A, 8'h5B, 8'hFF, 1'b1, 6'd2, 1'b0);
        driveBeat(8'h5A, 8'h5A, 8'hFF, 1'b1, 6'd2, 1'b0);
        driveBeat(8'h5A, 8'hDA, 8'hFF, 1'b1, 6'd2, 1'b1);
        expectVerdict("thr2", 1, 2, 3, 0);
        consume(0);

        // Same frame with threshold 1; mid-frame mode/threshold changes must be ignored.
        driveBeat(8'h5A, 8'h5B, 8'hFF, 1'b1, 6'd1, 1'b0);
        driveBeat(8'h5A, 8'h5A, 8'hFF, 1'b0, 6'd20, 1'b0);
        driveBeat(8'h5A, 8'hDA, 8'hFF, 1'b1, 6'd20, 1'b1);
        expectVerdict("thr1", 0, 2, 3, 0);
        consume(0);

        // Forced end at MAX_BEATS; the fifth beat opens a new frame.
        for (int i = 0; i < 4; i++) driveBeat(8'h00, 8'h01, 8'hFF, 1'b1, 6'd31, 1'b0);
        expectVerdict("forced", 0, 4, 4, 1);
        setBeat(8'h33, 8'h33, 8'hFF, 1'b0, 6'd0, 1'b1);
        check("forced in_ready", in_ready, 0);
        tick();
        check("forced hold beat_count", beat_count, 4);
        consume(0);
        driveBeat(8'h33, 8'h33, 8'hFF, 1'b0, 6'd0, 1'b1);
        expectVerdict("after forced", 1, 0, 1, 0);
        consume(0);

        // Backpressure: verdict held while a new beat waits, then handshake.
        driveBeat(8'h0F, 8'h00, 8'hFF, 1'b0, 6'd0, 1'b1);
        setBeat(8'h00, 8'h07, 8'hFF, 1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall out_valid", out_valid, 1);
            check("stall in_ready", in_ready, 0);
            check("stall match", match, 0);
            check("stall mismatch_count", mismatch_count, 4);
            check("stall beat_count", beat_count, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handshake out_valid", out_valid, 0);
        check("handshake in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        expectVerdict("post stall", 0, 3, 1, 0);
        consume(0);

        // Reset mid-frame wins over in_valid/out_ready and discards the partial frame.
        driveBeat(8'hFF, 8'h00, 8'hFF, 1'b0, 6'd0, 1'b0);
        driveBeat(8'hFF, 8'h00, 8'hFF, 1'b0, 6'd0, 1'b0);
        setBeat(8'h11, 8'h11, 8'hFF, 1'b0, 6'd0, 1'b1);
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("midreset out_valid", out_valid, 0);
        check("midreset in_ready", in_ready, 1);
        check("midreset match", match, 0);
        check("midreset mismatch_count", mismatch_count, 0);
        check("midreset beat_count", beat_count, 0);
        check("midreset frame_err", frame_err, 0);
        driveBeat(8'h01, 8'h00, 8'hFF, 1'b1, 6'd1, 1'b1);
        expectVerdict("after reset", 1, 1, 1, 0);
        consume(0);

        // Randomized frames against a frame-level model.
        for (int f = 0; f < 40; f++) begin
            int               n;
            int               expCnt;
            logic             frameMode;
            logic [CNT_W-1:0] frameThr;
            n      = $urandom_range(1, MAX_BEATS);
            expCnt = 0;
            for (int k = 0; k < n; k++) begin
                logic [7:0]       ra;
                logic [7:0]       rb;
                logic [7:0]       rm;
                logic             rmd;
                logic [CNT_W-1:0] rthr;
                ra   = 8'($urandom);
                rb   = ($urandom_range(0, 1) == 0) ? ra : 8'($urandom);
                rm   = 8'($urandom);
                rmd  = 1'($urandom);
                rthr = CNT_W'($urandom_range(0, 15));
                if (k == 0) begin
                    frameMode = rmd;
                    frameThr  = rthr;
                end
                expCnt += $countones((ra ^ rb) & rm);
                repeat ($urandom_range(0, 2)) tick();
                driveBeat(ra, rb, rm, rmd, rthr, k == n - 1);
            end
            expectVerdict($sformatf("rand%0d", f),
                          frameMode ? int'(expCnt <= int'(frameThr)) : int'(expCnt == 0),
                          expCnt, n, 0);
            consume($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xnor_frame_matcher.md
# xnor_frame_matcher

Parametrised, clocked successor to the two-input XNOR cell. Compares two WIDTH-bit words bitwise over a multi-beat frame, accumulates the masked mismatch count and reports one match verdict per frame. Supports exact-match or Hamming-threshold mode. Sits between the gate-level datapath primitives (`_and`, `_or`, `_nor`) and the control logic that consumes equality/similarity results.

## Interface
- `WIDTH`, 8, bits per beat per operand (≥1)
- `MAX_BEATS`, 16, longest legal frame in beats (≥1)
- `CNT_W`, `$clog2(WIDTH*MAX_BEATS+1)`, mismatch counter width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `DigitSupply`  in  2  supply pair; passed unchanged to every gate primitive instance, not interpreted by the block
- `in_valid`  in  1  beat present
- `in_ready`  out  1  block accepts a beat
- `in_last`  in  1  final beat of frame
- `A`, `B`  in  WIDTH  operands
- `mask`  in  WIDTH  1 = bit participates in the comparison
- `mode`  in  1  0 = exact, 1 = threshold; sampled on the first beat
- `threshold`  in  CNT_W  max tolerated mismatches in mode 1; sampled on the first beat
- `out_valid`  out  1  verdict present
- `out_ready`  in  1  consumer takes the verdict
- `match`  out  1  frame verdict
- `mismatch_count`  out  CNT_W  total masked mismatches in the frame
- `beat_count`  out  `$clog2(MAX_BEATS+1)`  beats in the frame
- `frame_err`  out  1  frame hit MAX_BEATS without `in_last`

## Operation
- Per beat, the lane forms `eq = A XNOR B`. It then computes `miss = popcount(~eq & mask)`.
- FSM states:
  - IDLE: no frame open; `in_ready`=1.
  - ACCUM: frame open; `in_ready`=1.
  - DONE: verdict held; `in_ready`=0.
- Accept a beat when `in_valid & in_ready`.
- IDLE + accept:
  - Latch `mode` and `threshold`.
  - Set `acc = miss` and `beats = 1`.
  - Go to DONE if `in_last`; otherwise go to ACCUM.
- ACCUM + accept:
  - `acc += miss`, saturating at all-ones of CNT_W.
  - `beats += 1`.
  - Go to DONE if `in_last` or `beats` reaches MAX_BEATS.
- Forced end (MAX_BEATS reached without `in_last`):
  - Set `frame_err` = 1 and `match` = 0.
  - Beats after the forced end start a new frame, even though they belong to the old one.
- Verdict on entry to DONE:
  - mode 0: `match = (acc == 0)`.
  - mode 1: `match = (acc <= threshold)`.
  - `match` is always 0 when `frame_err` = 1.
- DONE + `out_ready`: go to IDLE.
- Mask all-zero: the beat contributes 0 mismatches.
- Mode/threshold changes mid-frame are ignored.

## Timing
- Reset values (next edge with `rst`=1, regardless of state):
  - state = IDLE.
  - `in_ready` = 1 after reset.
  - `out_valid`, `match`, `frame_err` = 0.
  - `mismatch_count`, `beat_count` = 0.
  - Any partial frame is discarded.
- Latency: `out_valid` rises 1 cycle after the edge that accepted the last beat. Minimum frame-to-verdict time is 1 cycle for a single-beat frame.
- `in_ready` is registered, equal to (state != DONE).
- Verdict outputs are stable while `out_valid`=1 && `out_ready`=0.
- Throughput:
  - At most one frame per (beats + 1) cycles.
  - The beat following the verdict is accepted no earlier than the cycle after the `out_valid & out_ready` handshake.
- `out_valid` and `out_ready` can both be high while `in_valid` is presented. The beat is not accepted in that cycle because `in_ready`=0.
- `rst` asserted together with `out_ready` or `in_valid`: reset wins.

## Structure
- Package `xnor_match_pkg`:
  - FSM state enum {IDLE, ACCUM, DONE}.
  - Function `clog2_safe`.
  - Mode constants `MODE_EXACT` = 0 and `MODE_THRESH` = 1.
- Sub-module `xnor_lane`:
  - Purely combinational, parameter WIDTH.
  - Ports: DigitSupply, A, B, mask; outputs `eq[WIDTH]` and `miss`.
  - Per bit, builds XNOR from `_nor`, `_and`, `_or` primitives with INPUT_WIDTH=2, all sharing DigitSupply.
  - Popcount is an adder tree.
- Top: FSM, saturating accumulator, beat counter, verdict registers.

## Test plan
- WIDTH=8; single beat A=8'hA5, B=8'hA5, mask=8'hFF, mode 0, `in_last`=1 → next cycle `out_valid`=1, `match`=1, `mismatch_count`=0, `beat_count`=1.
- 3-beat frame, mode 1, threshold=2:
  - Beat mismatches 1, 0, 1 (e.g. B = A^8'h01, A, A^8'h80) → `mismatch_count`=2, `match`=1.
  - Repeat with threshold=1 → `match`=0.
- mask=8'h0F, A=8'hF0, B=8'h00 → `mismatch_count`=0, `match`=1 in mode 0.
- MAX_BEATS=4; 5 beats without `in_last` → verdict after beat 4 with `frame_err`=1, `match`=0, `beat_count`=4. Beat 5 is taken as the first beat of a new frame.
- Hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0, `in_valid` beats not accepted. Then `out_ready`=1 → IDLE next cycle.
- Assert `rst` for 1 cycle after beat 2 of a 4-beat frame → all outputs 0, no verdict. A new single-beat frame then produces a correct verdict.
